avst_avmm_mmio_master: RTL
==========================

Name: avst_avmm_mmio_master

Overview:
- Downstream neighbour of the CCI-P MMIO to Avalon-ST converter.
- Consumes packed MMIO command beats (read/write, 32/64-bit, byte address, write data) and issues them as Avalon-MM pipelined master transactions toward the AFU CSR fabric.
- Returns read data as an Avalon-ST response stream, in request order.
- Bounds outstanding reads by response-buffer credit, so no returned read data is ever lost.

Parameters:
- AVMM_ADDR_WIDTH, 16, byte-address width of command and master port.
- AVMM_DATA_WIDTH, 64, data width; fixed at 64 (byteenable logic is 8-lane).
- RSP_FIFO_DEPTH, 16, response buffer entries; power of two, >=2; also the max reads in flight.

Ports:
- clk  in  1  clock.
- SoftReset  in  1  synchronous active-high reset.
- in_data  in  AVMM_ADDR_WIDTH+AVMM_DATA_WIDTH+2  command beat; MSB..LSB = {is_read, is_32bit, addr[AW-1:0], write_data[DW-1:0]}.
- in_valid  in  1  command valid.
- in_ready  out  1  command accept; registered.
- out_data  out  AVMM_DATA_WIDTH  read response data.
- out_valid  out  1  response valid.
- out_ready  in  1  response accept.
- avm_address  out  AVMM_ADDR_WIDTH  byte address, low 3 bits zero.
- avm_read  out  1  read strobe.
- avm_write  out  1  write strobe.
- avm_writedata  out  64  write data.
- avm_byteenable  out  8  lane enables.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  64  read data.
- avm_readdatavalid  in  1  read data valid.
- rsp_overflow_err  out  1  sticky: readdatavalid arrived with no read outstanding.

Behaviour:
- Reset values: in_ready=0, avm_read=0, avm_write=0, out_valid=0, rsp_overflow_err=0, credit counter=0. Skid buffer and response FIFO are emptied. in_ready rises the cycle after SoftReset deasserts.
- Command intake:
  - 2-entry skid buffer; beat accepted when in_valid && in_ready.
  - in_ready = registered "skid has <=1 entry after this cycle".
  - Full throughput of 1 command/cycle when the slave does not stall.
- Issue FSM, states IDLE, ISSUE:
  - IDLE -> ISSUE when the skid head is valid and, for reads, credit < RSP_FIFO_DEPTH.
  - ISSUE holds avm_read/avm_write and all master outputs stable while avm_waitrequest=1.
  - When avm_waitrequest=0: the command completes and the skid head pops.
  - Back-to-back: ISSUE -> ISSUE when the next head is eligible the same cycle; else -> IDLE.
  - A read head with credit == RSP_FIFO_DEPTH stalls in IDLE. Writes behind it do not bypass (strict order).
- Address and lanes:
  - avm_address = {addr[AW-1:3],3'b000}.
  - is_32bit=0: byteenable=8'hFF.
  - is_32bit=1: addr[2]=0 gives 8'h0F; addr[2]=1 gives 8'hF0.
  - addr[1:0] ignored.
  - writedata passes unchanged; the upper-word copy is already placed by upstream.
- Credit:
  - Counter (log2(RSP_FIFO_DEPTH)+1 bits) = reads issued but not yet popped from the response FIFO.
  - +1 on a read accepted (avm_read && !avm_waitrequest).
  - -1 on a response pop (out_valid && out_ready).
  - Both in the same cycle: unchanged.
  - Never exceeds RSP_FIFO_DEPTH.
- Response path:
  - avm_readdatavalid pushes avm_readdata into the show-ahead response FIFO.
  - out_valid = !empty; out_data = FIFO head.
  - Push-to-out_valid latency is 1 cycle. Simultaneous push and pop on a non-empty FIFO is allowed.
  - The full 64-bit word is returned; the upstream stage selects the dword.
- Error handling:
  - readdatavalid while the count of reads accepted-but-not-returned is 0: data dropped, rsp_overflow_err set.
  - The flag clears only on SoftReset.
  - This is the case of stale responses after a mid-transaction reset.
- Reset mid-operation:
  - A transaction in ISSUE is abandoned; strobes drop the next edge.
  - Queued commands and buffered responses are discarded.

Decomposition:
- Shared package (mmio_avmm_pkg):
  - t_mmio_avst_cmd struct {is_read, is_32bit, addr, write_data}, used by this block and the upstream converter.
  - Localparam for byteenable encodings.
  - FSM enum t_mmio_issue_state.
- Sub-module mmio_rsp_fifo: parameterised show-ahead sync FIFO with full/empty/count, synchronous clear on SoftReset.

Test Plan:
- 64-bit write, addr=16'h0040, data=64'h1122334455667788, waitrequest=0 → one cycle with avm_write=1, address 16'h0040, byteenable 8'hFF, writedata unchanged.
- 32-bit write, addr=16'h0044, data=64'hAAAABBBBAAAABBBB → address 16'h0040, byteenable 8'hF0.
- Same write at addr=16'h0040 → byteenable 8'h0F.
- Read at 16'h0100 with waitrequest held high 3 cycles → avm_read and address stable for 4 cycles, asserted once. Slave readdata 64'hDEADBEEF0BADF00D two cycles later → out_valid with that data one cycle after readdatavalid.
- out_ready=0, issue 20 reads (RSP_FIFO_DEPTH=16), slave responds immediately → exactly 16 reads issued, read 17 stalls, in_ready falls once the skid is full. One pop → read 17 issues; no data lost and order preserved.
- Interleaved write, read, write with waitrequest toggling each cycle → master sees commands in input order; single response returned.
- SoftReset during ISSUE of a read, slave then asserts readdatavalid → strobes low the next cycle, out_valid stays 0, rsp_overflow_err=1 until the next reset.

Source files
------------

// File: rtl/mmio_avmm_pkg.sv
// Shared types for the MMIO command path between the CCI-P MMIO to Avalon-ST
// converter and the Avalon-MM master that follows it.
//   t_mmio_avst_cmd    : packed command beat {is_read, is_32bit, addr, write_data}
//   t_mmio_issue_state : issue FSM states of the Avalon-MM master
//   BE_*               : byteenable encodings, mmio_byteenable() selects one
package mmio_avmm_pkg;

    localparam int MMIO_CMD_AW = 16;
    localparam int MMIO_CMD_DW = 64;

    // Lane enables for a 64-bit data bus.
    localparam logic [7:0] BE_QWORD    = 8'hFF;
    localparam logic [7:0] BE_DWORD_LO = 8'h0F;
    localparam logic [7:0] BE_DWORD_HI = 8'hF0;

    typedef struct packed {
        logic                   is_read;
        logic                   is_32bit;
        logic [MMIO_CMD_AW-1:0] addr;
        logic [MMIO_CMD_DW-1:0] write_data;
    } t_mmio_avst_cmd;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } t_mmio_issue_state;

    // addr[2] picks the dword lane of a 32-bit access; addr[1:0] is ignored.
    function automatic logic [7:0] mmio_byteenable(input logic is_32bit,
                                                   input logic addr2);
        if (!is_32bit) return BE_QWORD;
        return addr2 ? BE_DWORD_HI : BE_DWORD_LO;
    endfunction

endpackage

// File: rtl/mmio_rsp_fifo.sv
// Show-ahead synchronous FIFO for read responses.
//   push/push_data : write side (push ignored when full)
//   pop            : read side, head is valid whenever !empty
//   empty/full/count : occupancy, registered
//   SoftReset      : synchronous clear of pointers and occupancy
module mmio_rsp_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     SoftReset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (SoftReset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/avst_avmm_mmio_master.sv
// Avalon-MM pipelined master fed by packed MMIO command beats.
//   in_*   : Avalon-ST command stream {is_read, is_32bit, addr, write_data}
//   avm_*  : Avalon-MM master toward the AFU CSR fabric
//   out_*  : Avalon-ST read-response stream, request order
//   rsp_overflow_err : sticky, readdatavalid seen with no read outstanding
// Reads are issued only while response-buffer credit is available, so the
// response FIFO can never overflow.
module avst_avmm_mmio_master
    import mmio_avmm_pkg::*;
#(
    parameter int AVMM_ADDR_WIDTH = MMIO_CMD_AW,
    parameter int AVMM_DATA_WIDTH = 64,
    parameter int RSP_FIFO_DEPTH  = 16
) (
    input  logic                                   clk,
    input  logic                                   SoftReset,
    input  logic [AVMM_ADDR_WIDTH+AVMM_DATA_WIDTH+1:0] in_data,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    output logic [AVMM_DATA_WIDTH-1:0]             out_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [AVMM_ADDR_WIDTH-1:0]             avm_address,
    output logic                                   avm_read,
    output logic                                   avm_write,
    output logic [63:0]                            avm_writedata,
    output logic [7:0]                             avm_byteenable,
    input  logic                                   avm_waitrequest,
    input  logic [63:0]                            avm_readdata,
    input  logic                                   avm_readdatavalid,
    output logic                                   rsp_overflow_err
);
    localparam int CW = $clog2(RSP_FIFO_DEPTH) + 1;

    t_mmio_avst_cmd    in_cmd, skid0, skid1, nxt0, nxt1;
    logic [1:0]        skid_cnt, skid_cnt_nxt, cnt_after_pop;
    t_mmio_issue_state state, state_nxt;
    logic [CW-1:0]     credit, credit_nxt, outst, outst_nxt;
    logic              push, pop, rd_acc, rsp_pop, rdv_take, head_elig;
    logic              fifo_empty, fifo_full;
    logic [CW-1:0]     fifo_count;

    assign in_cmd  = in_data;
    assign push    = in_valid && in_ready;
    assign pop     = (state == ST_ISSUE) && !avm_waitrequest;
    assign rd_acc  = pop && skid0.is_read;
    assign rsp_pop = out_valid && out_ready;
    // Responses with nothing outstanding are stale (e.g. after a reset) and dropped.
    assign rdv_take = avm_readdatavalid && (outst != '0);

    // Skid buffer next state: head pops by shifting, incoming beat lands
    // behind whatever remains.
    always_comb begin
        nxt0          = skid0;
        nxt1          = skid1;
        cnt_after_pop = skid_cnt - {1'b0, pop};
        if (pop) nxt0 = skid1;
        if (push) begin
            if (cnt_after_pop == 2'd0) nxt0 = in_cmd;
            else                       nxt1 = in_cmd;
        end
        skid_cnt_nxt = cnt_after_pop + {1'b0, push};
    end

    assign credit_nxt = credit + CW'(rd_acc) - CW'(rsp_pop);
    assign outst_nxt  = outst + CW'(rd_acc) - CW'(rdv_take);
    // Eligibility is judged on the head as it will be after this edge, which
    // lets a freshly accepted beat or the next queued one issue back-to-back.
    assign head_elig  = (skid_cnt_nxt != 2'd0) &&
                        (!nxt0.is_read || (credit_nxt < CW'(RSP_FIFO_DEPTH)));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (head_elig) state_nxt = ST_ISSUE;
            ST_ISSUE: if (!avm_waitrequest) state_nxt = head_elig ? ST_ISSUE : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (SoftReset) begin
            state            <= ST_IDLE;
            skid_cnt         <= 2'd0;
            in_ready         <= 1'b0;
            credit           <= '0;
            outst            <= '0;
            rsp_overflow_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            skid_cnt <= skid_cnt_nxt;
            in_ready <= (skid_cnt_nxt <= 2'd1);
            credit   <= credit_nxt;
            outst    <= outst_nxt;
            if (avm_readdatavalid && (outst == '0)) rsp_overflow_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        skid0 <= nxt0;
        skid1 <= nxt1;
    end

    // Master outputs come straight from the registered head, so they hold
    // steady for as long as waitrequest stalls the transfer.
    assign avm_read       = (state == ST_ISSUE) && skid0.is_read;
    assign avm_write      = (state == ST_ISSUE) && !skid0.is_read;
    assign avm_address    = {skid0.addr[AVMM_ADDR_WIDTH-1:3], 3'b000};
    assign avm_byteenable = mmio_byteenable(skid0.is_32bit, skid0.addr[2]);
    assign avm_writedata  = skid0.write_data;

    mmio_rsp_fifo #(
        .WIDTH (AVMM_DATA_WIDTH),
        .DEPTH (RSP_FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .SoftReset (SoftReset),
        .push      (rdv_take),
        .push_data (avm_readdata),
        .pop       (rsp_pop),
        .head      (out_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign out_valid = !fifo_empty;

    logic unused_ok;
    assign unused_ok = ^{fifo_full, fifo_count, skid0.addr[1:0]};
endmodule
